// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory pins plus the valid/ready link to decode.
// The master side is the fetch unit; the slave side is memory + decode.
interface inst_fetch_if #(
  parameter int DWIDTH = 8,
  parameter int ADDR   = 10
);
  logic              o_mem_csb;
  logic              o_mem_web;
  logic [ADDR-1:0]   o_mem_read_addr;
  logic [DWIDTH-1:0] i_mem_data;
  logic              o_inst_valid;
  logic [DWIDTH-1:0] o_inst;
  logic [ADDR-1:0]   o_inst_pc;
  logic              i_inst_ready;

  modport master (
    output o_mem_csb, o_mem_web, o_mem_read_addr,
    input  i_mem_data,
    output o_inst_valid, o_inst, o_inst_pc,
    input  i_inst_ready
  );

  modport slave (
    input  o_mem_csb, o_mem_web, o_mem_read_addr,
    output i_mem_data,
    input  o_inst_valid, o_inst, o_inst_pc,
    output i_inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: sequential PC issue, 1-cycle memory capture, 2-entry skid buffer, jump flush.
// Define IFETCH_STALL_CNT_EN to add the saturating decode-stall counter o_stall_cnt.
module inst_fetch #(
  parameter int DWIDTH = 8,
  parameter int ADDR   = 10
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_halt,
  input  logic            i_jump_valid,
  input  logic [ADDR-1:0] i_jump_addr,
  inst_fetch_if.master    bus
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [15:0]     o_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            state;
  logic [ADDR-1:0]   pc;
  logic [ADDR-1:0]   pending_pc;
  logic              rsp_pending;
  logic [1:0]        count;
  logic [DWIDTH-1:0] buf_inst [2];
  logic [ADDR-1:0]   buf_pc   [2];

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  assign pop       = bus.o_inst_valid & bus.i_inst_ready;
  assign push      = rsp_pending;
  assign occupancy = {1'b0, count} + {2'b00, rsp_pending};

  // A word leaving this cycle frees its slot, so the limit rises by one on a pop.
  assign issue = (state == RUN) && !i_halt && !i_jump_valid &&
                 (occupancy < (3'd2 + {2'b00, pop}));

  assign bus.o_mem_csb       = ~issue;
  assign bus.o_mem_web       = 1'b1;
  assign bus.o_mem_read_addr = pc;
  assign bus.o_inst_valid    = (count != 2'd0);
  assign bus.o_inst          = buf_inst[0];
  assign bus.o_inst_pc       = buf_pc[0];

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      pc          <= '0;
      pending_pc  <= '0;
      rsp_pending <= 1'b0;
    end else begin
      unique case (state)
        IDLE:    if (i_start) state <= RUN;
        RUN:     if (i_halt)  state <= HALT;
        HALT:    if (!i_halt) state <= RUN;
        default: state <= IDLE;
      endcase

      if (i_jump_valid) begin
        pc          <= i_jump_addr;
        rsp_pending <= 1'b0;
      end else begin
        rsp_pending <= issue;
        if (issue) begin
          pc         <= pc + 1'b1;
          pending_pc <= pc;
        end
      end
    end
  end

  // NOTE: the buffer is only two registers wide and its head drives o_inst,
  // so it is reset like ordinary state (a large RAM would not be).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count       <= 2'd0;
      buf_inst[0] <= '0;
      buf_inst[1] <= '0;
      buf_pc[0]   <= '0;
      buf_pc[1]   <= '0;
    end else if (i_jump_valid) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            buf_inst[0] <= bus.i_mem_data;
            buf_pc[0]   <= pending_pc;
          end else begin
            buf_inst[1] <= bus.i_mem_data;
            buf_pc[1]   <= pending_pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          buf_inst[0] <= buf_inst[1];
          buf_pc[0]   <= buf_pc[1];
          count       <= count - 2'd1;
        end
        2'b11: begin
          // Depth unchanged: the incoming word lands just behind the new head.
          if (count == 2'd1) begin
            buf_inst[0] <= bus.i_mem_data;
            buf_pc[0]   <= pending_pc;
          end else begin
            buf_inst[0] <= buf_inst[1];
            buf_pc[0]   <= buf_pc[1];
            buf_inst[1] <= bus.i_mem_data;
            buf_pc[1]   <= pending_pc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
    end else if (i_jump_valid) begin
      o_stall_cnt <= '0;
    end else if (bus.o_inst_valid && !bus.i_inst_ready && (o_stall_cnt != 16'hFFFF)) begin
      o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch; memory holds mem[n] = n + 8'h10.
// Build with IFETCH_STALL_CNT_EN defined to also check o_stall_cnt.
module tb_inst_fetch;
  localparam int DWIDTH = 8;
  localparam int ADDR   = 10;

  typedef struct packed {
    logic [ADDR-1:0]   pc;
    logic [DWIDTH-1:0] inst;
  } exp_t;

  typedef enum int {M_IDLE, M_RUN, M_HALT} mode_t;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_start;
  logic            i_halt;
  logic            i_jump_valid;
  logic [ADDR-1:0] i_jump_addr;
`ifdef IFETCH_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  inst_fetch_if #(.DWIDTH(DWIDTH), .ADDR(ADDR)) bus ();

  inst_fetch #(.DWIDTH(DWIDTH), .ADDR(ADDR)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_halt       (i_halt),
    .i_jump_valid (i_jump_valid),
    .i_jump_addr  (i_jump_addr),
    .bus          (bus)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .o_stall_cnt  (stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Synchronous-read instruction memory, contents defined by rule.
  always @(posedge i_clk) begin
    if (!bus.o_mem_csb) bus.i_mem_data <= 8'(bus.o_mem_read_addr) + 8'h10;
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pipeline occupancy, next PC, mode and expected word stream.
  mode_t           m_mode;
  int              m_count;
  int              m_pend;
  logic [ADDR-1:0] m_pc;
  int              m_stall;
  int              d_out;
  exp_t            exp_q[$];
  bit              m_valid, m_pop, m_issue;
  exp_t            e;

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_count = 0;
    m_pend  = 0;
    m_pc    = '0;
    m_stall = 0;
    d_out   = 0;
    exp_q.delete();
  endtask

  always @(negedge i_clk) begin
    if (i_rst === 1'b0) begin
      m_valid = (m_count != 0);
      m_pop   = m_valid && bus.i_inst_ready;
      check("inst_valid", 32'(bus.o_inst_valid), 32'(m_valid));
      if (bus.o_inst_valid && bus.i_inst_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_empty: word pc %0h delivered with nothing expected", bus.o_inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("inst", 32'(bus.o_inst), 32'(e.inst));
          check("inst_pc", 32'(bus.o_inst_pc), 32'(e.pc));
        end
      end

      m_issue = (m_mode == M_RUN) && !i_halt && !i_jump_valid &&
                ((m_count + m_pend - int'(m_pop)) < 2);
      check("mem_csb", 32'(bus.o_mem_csb), 32'(!m_issue));
      check("mem_web", 32'(bus.o_mem_web), 32'd1);
      if (m_issue) check("read_addr", 32'(bus.o_mem_read_addr), 32'(m_pc));
`ifdef IFETCH_STALL_CNT_EN
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif

      // Occupancy as seen purely from DUT pins: reads issued minus words taken.
      if (i_jump_valid) d_out = 0;
      else d_out = d_out + int'(!bus.o_mem_csb) - int'(bus.o_inst_valid && bus.i_inst_ready);
      check("occupancy_le_2", 32'(d_out <= 2), 32'd1);

      if (i_jump_valid) begin
        m_count = 0;
        m_pend  = 0;
        m_pc    = i_jump_addr;
        m_stall = 0;
        exp_q.delete();
      end else begin
        if (m_valid && !bus.i_inst_ready && m_stall != 16'hFFFF) m_stall++;
        m_count = m_count - int'(m_pop) + m_pend;
        m_pend  = int'(m_issue);
        if (m_issue) begin
          exp_q.push_back('{pc: m_pc, inst: 8'(m_pc) + 8'h10});
          m_pc = m_pc + 1'b1;
        end
      end

      unique case (m_mode)
        M_IDLE:  if (i_start) m_mode = M_RUN;
        M_RUN:   if (i_halt)  m_mode = M_HALT;
        default: if (!i_halt) m_mode = M_RUN;
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic reset_checks();
    check("rst_valid", 32'(bus.o_inst_valid), 32'd0);
    check("rst_csb", 32'(bus.o_mem_csb), 32'd1);
    check("rst_addr", 32'(bus.o_mem_read_addr), 32'd0);
    check("rst_inst", 32'(bus.o_inst), 32'd0);
    check("rst_inst_pc", 32'(bus.o_inst_pc), 32'd0);
`ifdef IFETCH_STALL_CNT_EN
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
  endtask

  task automatic jump(input logic [ADDR-1:0] addr);
    i_jump_valid = 1'b1;
    i_jump_addr  = addr;
    step(1);
    i_jump_valid = 1'b0;
  endtask

  initial begin
    int lat;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_halt = 1'b0;
    i_jump_valid = 1'b0;
    i_jump_addr = '0;
    bus.i_inst_ready = 1'b1;
    bus.i_mem_data = '0;
    model_reset();
    step(2);
    reset_checks();
    i_rst = 1'b0;
    step(1);

    // Start-to-first-word latency, then a free-running stream.
    i_start = 1'b1;
    lat = 0;
    step(1);
    i_start = 1'b0;
    lat = 1;
    while (!bus.o_inst_valid && lat < 10) begin
      step(1);
      lat++;
    end
    check("start_latency", 32'(lat), 32'd3);
    step(20);

    // Back-pressure mid-stream.
    bus.i_inst_ready = 1'b0;
    step(5);
    bus.i_inst_ready = 1'b1;
    step(10);

    // Redirect while running, then across the address wrap.
    jump(10'h200);
    check("jump_flush_valid", 32'(bus.o_inst_valid), 32'd0);
    step(10);
    jump(10'h3FE);
    step(8);

    // Halt for four cycles.
    i_halt = 1'b1;
    step(4);
    i_halt = 1'b0;
    step(10);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bus.i_inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) i_halt = ~i_halt;
      i_start      = ($urandom_range(0, 31) == 0);
      i_jump_valid = ($urandom_range(0, 39) == 0);
      i_jump_addr  = ADDR'($urandom);
      step(1);
    end
    i_start = 1'b0;
    i_jump_valid = 1'b0;
    i_halt = 1'b0;
    bus.i_inst_ready = 1'b1;
    step(10);

    // Reset during a stall with the buffer full.
    i_rst = 1'b1;
    #1;
    model_reset();
    step(1);
    i_rst = 1'b0;
    bus.i_inst_ready = 1'b0;
    pulse_start();
    lat = 0;
    while (!bus.o_inst_valid && lat < 10) begin
      step(1);
      lat++;
    end
    check("stall_fill_valid", 32'(bus.o_inst_valid), 32'd1);
    step(7);
`ifdef IFETCH_STALL_CNT_EN
    check("stall_cnt_7", 32'(stall_cnt), 32'd7);
`endif
    i_rst = 1'b1;
    #1;
    model_reset();
    reset_checks();
    step(2);
    i_rst = 1'b0;
    bus.i_inst_ready = 1'b1;

    // Redirect in IDLE moves only the PC; the run then starts from it.
    jump(10'h100);
    step(3);
    check("idle_jump_csb", 32'(bus.o_mem_csb), 32'd1);
    pulse_start();
    step(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage directly upstream of the instruction memory.
- Generates sequential read addresses, drives the memory's chip-select/write-enable/read-address pins, and captures the 1-cycle-latency read data.
- Presents fetched words with their PC to the decode stage through a valid/ready handshake.
- Holds a 2-entry skid buffer so back-pressure never loses an in-flight word; supports jump redirect with flush.

Parameters:
- DWIDTH, 8, instruction word width (matches memory data width)
- ADDR, 10, PC / memory address width

Ports:
- i_clk  in  1  fetch clock, same clock as the instruction memory
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  pulse; IDLE -> RUN
- i_halt  in  1  level; while high, no new reads issued
- i_jump_valid  in  1  redirect request
- i_jump_addr  in  ADDR  redirect target PC
- o_mem_csb  out  1  memory chip select, 0 = access
- o_mem_web  out  1  memory write enable, tied 1 (read)
- o_mem_read_addr  out  ADDR  memory read address (= PC)
- i_mem_data  in  DWIDTH  memory read data, valid 1 cycle after issue
- o_inst_valid  out  1  instruction available to decode
- o_inst  out  DWIDTH  instruction word (head of buffer)
- o_inst_pc  out  ADDR  PC of o_inst
- i_inst_ready  in  1  decode accepts; transfer = valid & ready

Behaviour:
- Reset (async, i_rst=1): state=IDLE, PC=0, buffer empty, rsp_pending=0, o_mem_csb=1, o_mem_read_addr=0, o_inst_valid=0, o_inst=0, o_inst_pc=0. o_mem_web=1 always.
- FSM:
  - IDLE: no issue. i_start -> RUN.
  - RUN: issues reads. i_halt=1 -> HALT.
  - HALT: no issue; in-flight read still captured; buffer keeps draining to decode. i_halt=0 -> RUN.
  - i_start in RUN/HALT is ignored.
- Issue:
  - Condition: state==RUN, i_halt=0, i_jump_valid=0, and (count + rsp_pending - pop) < 2, where pop = o_inst_valid & i_inst_ready.
  - On issue: o_mem_csb=0 combinationally that cycle, o_mem_read_addr=PC; at the edge PC <= PC+1 (mod 2^ADDR, wraps 1023->0), rsp_pending <= 1, pending_pc <= PC.
  - No issue: o_mem_csb=1, rsp_pending <= 0.
- Response: at the edge after an issue edge (rsp_pending=1), push {i_mem_data, pending_pc} into the buffer.
- Throughput: 1 word/cycle when i_inst_ready is held high. Latency: start pulse at edge 0 -> first issue cycle 1 -> o_inst_valid high after edge 3.
- Buffer: 2-entry FIFO, o_inst/o_inst_pc = head. Push and pop in the same cycle are both honoured. Overflow is impossible by construction; the bench asserts count<=2.
- Redirect (i_jump_valid=1, any state):
  - At the edge: buffer cleared, rsp_pending cleared (the response arriving at that edge is dropped), PC <= i_jump_addr.
  - No issue in the redirect cycle.
  - o_inst_valid=0 the following cycle.
  - In IDLE only PC updates; the state stays IDLE.
  - Redirect has priority over pop: a pop in the same cycle still completes for decode, since decode sampled it.
- Reset mid-operation: everything returns to reset values immediately; the pending memory response is ignored.

Optional Feature:
- Macro: IFETCH_STALL_CNT_EN
- Defined: adds output o_stall_cnt (16 bits), reset 0.
  - Increments each cycle o_inst_valid=1 and i_inst_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared on redirect.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Memory preloaded with mem[n]=n+8'h10. Reset, i_start, i_inst_ready=1 -> o_mem_csb low every cycle from cycle 1; decode receives 0x10,0x11,0x12... with PC 0,1,2..., one per cycle, first valid 3 cycles after start.
- i_inst_ready=0 for 5 cycles mid-stream -> at most 2 words buffered; csb high while full; on release the sequence continues with no gap or duplicate.
- i_jump_valid with i_jump_addr=0x200 while running -> next valid word is mem[0x200]=0x10 with PC 0x200; the in-flight word is never presented.
- PC at 0x3FE, run 4 words -> PCs 0x3FE, 0x3FF, 0x000, 0x001.
- i_halt high 4 cycles -> csb stays high, buffered words drain, no new PCs; i_halt low -> resumes at the next sequential PC.
- Assert i_rst during a stall with 2 words buffered -> o_inst_valid=0 and o_mem_csb=1 immediately, PC=0. With IFETCH_STALL_CNT_EN, 7 stall cycles -> o_stall_cnt=7, and reset returns it to 0.
